// File: rtl/mem_bus_arbiter_if.sv
// Bundle of CPU/DMA request ports and multiplexed memory-bus pins for mem_bus_arbiter.
// master = arbiter view, slave = requesters/memory view.
interface mem_bus_arbiter_if #(
   parameter int DATA_W = 16
);
   logic              cpu_req;
   logic              cpu_rnw;
   logic [DATA_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic              dma_req;
   logic              dma_rnw;
   logic [DATA_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_ack;
   logic [DATA_W-1:0] rdata;
   logic [DATA_W-1:0] data_out;
   logic [DATA_W-1:0] data_in;
   logic              ale;
   logic              n_me;
   logic              n_oe;
   logic              rnw;
   logic              enb;
   logic              n_wait;
   logic              bus_err;

   modport master (
      input  cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
      input  dma_req, dma_rnw, dma_addr, dma_wdata,
      input  data_in, n_wait,
      output cpu_ack, dma_ack, rdata, data_out,
      output ale, n_me, n_oe, rnw, enb, bus_err
   );

   modport slave (
      output cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
      output dma_req, dma_rnw, dma_addr, dma_wdata,
      output data_in, n_wait,
      input  cpu_ack, dma_ack, rdata, data_out,
      input  ale, n_me, n_oe, rnw, enb, bus_err
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin CPU/DMA arbiter driving a multiplexed ADDR/DATA memory bus with registered outputs.
// Optional MEM_WAIT_TIMEOUT_EN aborts a DATA phase after MAX_WAIT nWait-low cycles and flags BusErr.
module mem_bus_arbiter #(
   parameter int DATA_W = 16
`ifdef MEM_WAIT_TIMEOUT_EN
   ,
   parameter int MAX_WAIT = 15
`endif
) (
   input  logic              clk,
   input  logic              rst,
   mem_bus_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   state_t            state, state_nx;
   logic              last_dma, last_dma_nx;
   logic              sel_dma, sel_dma_nx;
   logic              pick_dma;
   logic              op_rd, op_rd_nx;
   logic [DATA_W-1:0] wdata_q, wdata_nx;
   logic [DATA_W-1:0] data_out_q, data_out_nx;
   logic [DATA_W-1:0] rdata_q, rdata_nx;
   logic              ale_q, ale_nx;
   logic              n_me_q, n_me_nx;
   logic              n_oe_q, n_oe_nx;
   logic              rnw_q, rnw_nx;
   logic              enb_q, enb_nx;
   logic              cpu_ack_q, cpu_ack_nx;
   logic              dma_ack_q, dma_ack_nx;
`ifdef MEM_WAIT_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   logic [CNT_W-1:0]  wait_cnt, wait_cnt_nx;
   logic              bus_err_q, bus_err_nx;
`endif

   always_comb begin
      state_nx    = state;
      last_dma_nx = last_dma;
      sel_dma_nx  = sel_dma;
      pick_dma    = 1'b0;
      op_rd_nx    = op_rd;
      wdata_nx    = wdata_q;
      data_out_nx = data_out_q;
      rdata_nx    = rdata_q;
`ifdef MEM_WAIT_TIMEOUT_EN
      wait_cnt_nx = wait_cnt;
      bus_err_nx  = 1'b0;
`endif
      case (state)
         IDLE: begin
            // last_dma only moves on a tie, so the CPU wins the first tie after reset
            if (bus.cpu_req && bus.dma_req) begin
               pick_dma    = !last_dma;
               last_dma_nx = !last_dma;
            end else begin
               pick_dma = bus.dma_req;
            end
            if (bus.cpu_req || bus.dma_req) begin
               sel_dma_nx  = pick_dma;
               op_rd_nx    = pick_dma ? bus.dma_rnw   : bus.cpu_rnw;
               wdata_nx    = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
               data_out_nx = pick_dma ? bus.dma_addr  : bus.cpu_addr;
               state_nx    = ADDR;
            end
         end
         ADDR: begin
            state_nx = DATA;
            if (!op_rd) data_out_nx = wdata_q;
`ifdef MEM_WAIT_TIMEOUT_EN
            wait_cnt_nx = '0;
`endif
         end
         DATA: begin
            if (bus.n_wait) begin
               state_nx = DONE;
               if (op_rd) rdata_nx = bus.data_in;
            end
`ifdef MEM_WAIT_TIMEOUT_EN
            else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
               state_nx   = DONE;
               bus_err_nx = 1'b1;
            end else begin
               wait_cnt_nx = wait_cnt + 1'b1;
            end
`endif
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase

      // Bus pins are decoded from the next state so they change together with it
      ale_nx     = 1'b0;
      n_me_nx    = 1'b1;
      n_oe_nx    = 1'b1;
      rnw_nx     = 1'b1;
      enb_nx     = 1'b0;
      cpu_ack_nx = 1'b0;
      dma_ack_nx = 1'b0;
      case (state_nx)
         ADDR: begin
            ale_nx = 1'b1;
            enb_nx = 1'b1;
            rnw_nx = op_rd_nx;
         end
         DATA: begin
            n_me_nx = 1'b0;
            rnw_nx  = op_rd;
            n_oe_nx = !op_rd;
            enb_nx  = !op_rd;
         end
         DONE: begin
            cpu_ack_nx = !sel_dma;
            dma_ack_nx = sel_dma;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_dma   <= 1'b1;
         sel_dma    <= 1'b0;
         data_out_q <= '0;
         rdata_q    <= '0;
         ale_q      <= 1'b0;
         n_me_q     <= 1'b1;
         n_oe_q     <= 1'b1;
         rnw_q      <= 1'b1;
         enb_q      <= 1'b0;
         cpu_ack_q  <= 1'b0;
         dma_ack_q  <= 1'b0;
`ifdef MEM_WAIT_TIMEOUT_EN
         wait_cnt   <= '0;
         bus_err_q  <= 1'b0;
`endif
      end else begin
         state      <= state_nx;
         last_dma   <= last_dma_nx;
         sel_dma    <= sel_dma_nx;
         data_out_q <= data_out_nx;
         rdata_q    <= rdata_nx;
         ale_q      <= ale_nx;
         n_me_q     <= n_me_nx;
         n_oe_q     <= n_oe_nx;
         rnw_q      <= rnw_nx;
         enb_q      <= enb_nx;
         cpu_ack_q  <= cpu_ack_nx;
         dma_ack_q  <= dma_ack_nx;
`ifdef MEM_WAIT_TIMEOUT_EN
         wait_cnt   <= wait_cnt_nx;
         bus_err_q  <= bus_err_nx;
`endif
      end
   end

   // Latched request fields are only consumed after a grant, so they carry no reset
   always_ff @(posedge clk) begin
      op_rd   <= op_rd_nx;
      wdata_q <= wdata_nx;
   end

   assign bus.cpu_ack  = cpu_ack_q;
   assign bus.dma_ack  = dma_ack_q;
   assign bus.rdata    = rdata_q;
   assign bus.data_out = data_out_q;
   assign bus.ale      = ale_q;
   assign bus.n_me     = n_me_q;
   assign bus.n_oe     = n_oe_q;
   assign bus.rnw      = rnw_q;
   assign bus.enb      = enb_q;
`ifdef MEM_WAIT_TIMEOUT_EN
   assign bus.bus_err  = bus_err_q;
`else
   assign bus.bus_err  = 1'b0;
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: expected acks are queued at stimulus time and checked as they appear.
// Define MEM_WAIT_TIMEOUT_EN for both files to exercise the timeout path.
module tb_mem_bus_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_bus_arbiter_if #(.DATA_W(16)) bus ();

   mem_bus_arbiter #(.DATA_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        dma;
      logic [15:0] rdata;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input logic dma, input logic [15:0] rd, input logic err);
      exp_t e;
      e.dma   = dma;
      e.rdata = rd;
      e.err   = err;
      exp_q.push_back(e);
   endtask

   // Scoreboard: every ack must match the oldest queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (bus.cpu_ack === 1'b1 || bus.dma_ack === 1'b1) begin
         check("ack_exclusive", {31'b0, bus.cpu_ack & bus.dma_ack}, 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_ack", {31'b0, bus.cpu_ack | bus.dma_ack}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("ack_master", {31'b0, bus.dma_ack}, {31'b0, e.dma});
            check("ack_rdata", {16'b0, bus.rdata}, {16'b0, e.rdata});
            check("ack_bus_err", {31'b0, bus.bus_err}, {31'b0, e.err});
         end
      end
   end

   initial begin
      int dcyc;
      int ack_at;
      int acks;
      int last_k;
      logic got;
      logic exp_dma;

      bus.cpu_req = 0; bus.cpu_rnw = 1; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dma_req = 0; bus.dma_rnw = 1; bus.dma_addr = '0; bus.dma_wdata = '0;
      bus.data_in = '0; bus.n_wait = 1;
      rst = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ale", {31'b0, bus.ale}, 32'd0);
      check("rst_n_me", {31'b0, bus.n_me}, 32'd1);
      check("rst_n_oe", {31'b0, bus.n_oe}, 32'd1);
      check("rst_rnw", {31'b0, bus.rnw}, 32'd1);
      check("rst_enb", {31'b0, bus.enb}, 32'd0);
      check("rst_data_out", {16'b0, bus.data_out}, 32'd0);
      check("rst_rdata", {16'b0, bus.rdata}, 32'd0);
      check("rst_acks", {30'b0, bus.cpu_ack, bus.dma_ack}, 32'd0);
      check("rst_bus_err", {31'b0, bus.bus_err}, 32'd0);
      rst = 0;

      // CPU read, no wait states
      bus.cpu_req = 1; bus.cpu_rnw = 1; bus.cpu_addr = 16'h1234;
      bus.data_in = 16'hBEEF; bus.n_wait = 1;
      push(1'b0, 16'hBEEF, 1'b0);
      step();
      check("t1_addr_ale", {31'b0, bus.ale}, 32'd1);
      check("t1_addr_bus", {16'b0, bus.data_out}, 32'h1234);
      check("t1_addr_enb", {31'b0, bus.enb}, 32'd1);
      check("t1_addr_n_me", {31'b0, bus.n_me}, 32'd1);
      check("t1_addr_rnw", {31'b0, bus.rnw}, 32'd1);
      step();
      check("t1_data_ale", {31'b0, bus.ale}, 32'd0);
      check("t1_data_n_me", {31'b0, bus.n_me}, 32'd0);
      check("t1_data_n_oe", {31'b0, bus.n_oe}, 32'd0);
      check("t1_data_enb", {31'b0, bus.enb}, 32'd0);
      step();
      check("t1_done_cpu_ack", {31'b0, bus.cpu_ack}, 32'd1);
      check("t1_done_n_me", {31'b0, bus.n_me}, 32'd1);
      check("t1_done_n_oe", {31'b0, bus.n_oe}, 32'd1);
      check("t1_rdata", {16'b0, bus.rdata}, 32'hBEEF);
      bus.cpu_req = 0;
      step();
      check("t1_idle_ack", {30'b0, bus.cpu_ack, bus.dma_ack}, 32'd0);

      // DMA write with three wait edges; request dropped mid-transaction
      bus.dma_req = 1; bus.dma_rnw = 0; bus.dma_addr = 16'h0040; bus.dma_wdata = 16'hA5A5;
      bus.n_wait = 0;
      push(1'b1, 16'hBEEF, 1'b0);
      step();
      check("t2_addr_ale", {31'b0, bus.ale}, 32'd1);
      check("t2_addr_bus", {16'b0, bus.data_out}, 32'h0040);
      check("t2_addr_rnw", {31'b0, bus.rnw}, 32'd0);
      check("t2_addr_enb", {31'b0, bus.enb}, 32'd1);
      dcyc = 0; ack_at = 0; got = 0;
      for (int k = 2; k <= 20 && !got; k++) begin
         step();
         if (bus.dma_ack === 1'b1) begin
            got = 1; ack_at = k;
         end else if (bus.n_me === 1'b0) begin
            dcyc++;
            check("t2_data_enb", {31'b0, bus.enb}, 32'd1);
            check("t2_data_rnw", {31'b0, bus.rnw}, 32'd0);
            check("t2_data_bus", {16'b0, bus.data_out}, 32'hA5A5);
            check("t2_data_n_oe", {31'b0, bus.n_oe}, 32'd1);
            bus.n_wait = (dcyc >= 4);
            if (dcyc == 2) bus.dma_req = 0;
         end
      end
      check("t2_got_ack", {31'b0, got}, 32'd1);
      check("t2_n_me_low_cycles", dcyc, 32'd4);
      check("t2_ack_cycle", ack_at, 32'd6);
      bus.n_wait = 1;
      step();

      // Tie after reset: CPU first, then strict alternation every 4 cycles
      rst = 1;
      step();
      rst = 0;
      bus.cpu_req = 1; bus.cpu_rnw = 1; bus.cpu_addr = 16'h1111;
      bus.dma_req = 1; bus.dma_rnw = 1; bus.dma_addr = 16'h2222;
      bus.data_in = 16'h0C0D; bus.n_wait = 1;
      push(1'b0, 16'h0C0D, 1'b0);
      push(1'b1, 16'h0C0D, 1'b0);
      push(1'b0, 16'h0C0D, 1'b0);
      push(1'b1, 16'h0C0D, 1'b0);
      acks = 0; last_k = 0; exp_dma = 0;
      for (int k = 1; k <= 40 && acks < 4; k++) begin
         step();
         if (bus.cpu_ack === 1'b1 || bus.dma_ack === 1'b1) begin
            check("t3_grant_order", {31'b0, bus.dma_ack}, {31'b0, exp_dma});
            if (acks == 0) check("t3_first_latency", k, 32'd3);
            else check("t3_ack_spacing", k - last_k, 32'd4);
            last_k = k;
            acks++;
            exp_dma = !exp_dma;
            if (acks == 4) begin
               bus.cpu_req = 0;
               bus.dma_req = 0;
            end
         end
      end
      check("t3_ack_count", acks, 32'd4);
      step();

      // Reset during the DATA phase of a read, then a fresh request
      bus.cpu_req = 1; bus.cpu_rnw = 1; bus.cpu_addr = 16'h3333;
      bus.data_in = 16'hDEAD; bus.n_wait = 0;
      step();
      step();
      check("t4_in_data", {31'b0, bus.n_me}, 32'd0);
      rst = 1;
      step();
      check("t4_rst_n_me", {31'b0, bus.n_me}, 32'd1);
      check("t4_rst_n_oe", {31'b0, bus.n_oe}, 32'd1);
      check("t4_rst_ale", {31'b0, bus.ale}, 32'd0);
      check("t4_rst_enb", {31'b0, bus.enb}, 32'd0);
      check("t4_rst_ack", {30'b0, bus.cpu_ack, bus.dma_ack}, 32'd0);
      check("t4_rst_rdata", {16'b0, bus.rdata}, 32'd0);
      rst = 0;
      bus.cpu_addr = 16'h4444; bus.data_in = 16'h1357; bus.n_wait = 1;
      push(1'b0, 16'h1357, 1'b0);
      step();
      check("t4_restart_ale", {31'b0, bus.ale}, 32'd1);
      check("t4_restart_bus", {16'b0, bus.data_out}, 32'h4444);
      got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
         step();
         if (bus.cpu_ack === 1'b1) begin
            got = 1;
            bus.cpu_req = 0;
         end
      end
      check("t4_restart_ack", {31'b0, got}, 32'd1);
      step();

      // nWait stuck low on a DMA read
      bus.dma_req = 1; bus.dma_rnw = 1; bus.dma_addr = 16'h5555;
      bus.data_in = 16'h9999; bus.n_wait = 0;
      step();
      bus.dma_req = 0;
`ifdef MEM_WAIT_TIMEOUT_EN
      push(1'b1, 16'h1357, 1'b1);
      dcyc = 0; got = 0;
      for (int k = 0; k < 40 && !got; k++) begin
         step();
         if (bus.dma_ack === 1'b1) begin
            got = 1;
            check("t5_bus_err", {31'b0, bus.bus_err}, 32'd1);
         end else if (bus.n_me === 1'b0) begin
            dcyc++;
         end
      end
      check("t5_timeout_ack", {31'b0, got}, 32'd1);
      check("t5_data_cycles", dcyc, 32'd15);
`else
      acks = 0;
      for (int k = 0; k < 100; k++) begin
         step();
         if (bus.cpu_ack === 1'b1 || bus.dma_ack === 1'b1) acks++;
      end
      check("t5_no_ack", acks, 32'd0);
      check("t5_still_data", {31'b0, bus.n_me}, 32'd0);
      check("t5_bus_err_tied", {31'b0, bus.bus_err}, 32'd0);
`endif
      bus.n_wait = 1;
      rst = 1;
      step();
      rst = 0;
      step();
      check("end_idle_n_me", {31'b0, bus.n_me}, 32'd1);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
